// File: rtl/regwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regwr_pkg
//  Description : Shared constants and FSM state type for the 8x16 register
//                write demux and its companion result selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package regwr_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_DEST  = 8;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dec3to8_en.sv
`default_nettype none
// ============================================================================
//  Module      : dec3to8_en
//  Description : Enabled 3-to-8 one-hot decoder; all outputs low when en=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec3to8_en
    import regwr_pkg::*;
(
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_DEST-1:0] onehot
);

    generate
        for (genvar k = 0; k < NUM_DEST; k++) begin : g_bit
            assign onehot[k] = en && (sel == SEL_W'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demux_8x16_regwr.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8x16_regwr
//  Description : Valid/ready write demux into eight holding registers with a
//                one-register-per-cycle bank clear sweep.
//                Optional macro DEMUX_R0_ZERO_EN: out0 hard-wired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_8x16_regwr
    import regwr_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                clr_req,
    output logic                busy,
    output logic [NUM_DEST-1:0] upd,
    output logic [WIDTH-1:0]    out0,
    output logic [WIDTH-1:0]    out1,
    output logic [WIDTH-1:0]    out2,
    output logic [WIDTH-1:0]    out3,
    output logic [WIDTH-1:0]    out4,
    output logic [WIDTH-1:0]    out5,
    output logic [WIDTH-1:0]    out6,
    output logic [WIDTH-1:0]    out7
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_clr_idx;
    logic [SEL_W-1:0]    w_clr_idx_nxt;
    logic                w_ready;
    logic                w_busy;
    logic                w_accept;

    logic                r_acc_vld;
    logic [SEL_W-1:0]    r_acc_sel;
    logic [WIDTH-1:0]    r_acc_data;

    logic [NUM_DEST-1:0] w_wen_raw;
    logic [NUM_DEST-1:0] w_wen;
    logic [NUM_DEST-1:0] w_clr_en;
    logic [NUM_DEST-1:0] r_upd;
    logic [WIDTH-1:0]    w_out [NUM_DEST];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // A clear request in IDLE blocks a simultaneous write so the clear wins.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_ready       = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !clr_req;
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            CLEAR: begin
                w_busy        = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == SEL_W'(NUM_DEST - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = wr_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_vld  <= 1'b0;
            r_acc_sel  <= '0;
            r_acc_data <= '0;
        end else begin
            r_acc_vld <= w_accept;
            if (w_accept) begin
                r_acc_sel  <= wr_sel;
                r_acc_data <= wr_data;
            end
        end
    end

    dec3to8_en u_dec_wr (
        .en     (r_acc_vld),
        .sel    (r_acc_sel),
        .onehot (w_wen_raw)
    );

    dec3to8_en u_dec_clr (
        .en     (w_busy),
        .sel    (r_clr_idx),
        .onehot (w_clr_en)
    );

`ifdef DEMUX_R0_ZERO_EN
    assign w_wen = {w_wen_raw[NUM_DEST-1:1], 1'b0};
`else
    assign w_wen = w_wen_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd <= '0;
        end else begin
            r_upd <= w_wen;
        end
    end

    generate
        for (genvar k = 0; k < NUM_DEST; k++) begin : g_reg
`ifdef DEMUX_R0_ZERO_EN
            if (k == 0) begin : g_zero
                assign w_out[k] = '0;
            end else begin : g_hold
`else
            begin : g_hold
`endif
                logic [WIDTH-1:0] r_hold;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_hold <= CLR_VAL;
                    end else if (w_clr_en[k]) begin
                        r_hold <= CLR_VAL;
                    end else if (w_wen[k]) begin
                        r_hold <= r_acc_data;
                    end
                end

                assign w_out[k] = r_hold;
            end
        end
    endgenerate

    assign wr_ready = w_ready;
    assign busy     = w_busy;
    assign upd      = r_upd;
    assign out0     = w_out[0];
    assign out1     = w_out[1];
    assign out2     = w_out[2];
    assign out3     = w_out[3];
    assign out4     = w_out[4];
    assign out5     = w_out[5];
    assign out6     = w_out[6];
    assign out7     = w_out[7];

endmodule
`default_nettype wire

// File: tb/tb_demux_8x16_regwr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_8x16_regwr
//  Description : Scoreboard bench for demux_8x16_regwr with random writes,
//                bank clears and resets against a register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_8x16_regwr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic [7:0]  upd;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [15:0] outs [8];

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    always #5 clk = ~clk;

    demux_8x16_regwr u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .upd      (upd),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .out6     (out6),
        .out7     (out7)
    );

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q [$];
    logic [15:0] mem [8];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_all();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("out%0d", k), 32'(outs[k]), 32'(mem[k]));
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
    endtask

    // Model of an accepted write: it lands in the register file, and a
    // commit strobe is expected later unless register 0 is hard-wired.
    task automatic push_exp(input logic [2:0] s, input logic [15:0] d);
        wr_t e;
        e.sel  = s;
        e.data = d;
`ifdef DEMUX_R0_ZERO_EN
        if (s != 3'd0) begin
            exp_q.push_back(e);
            mem[s] = d;
        end
`else
        exp_q.push_back(e);
        mem[s] = d;
`endif
    endtask

    task automatic do_write(input logic [2:0] s, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_data  = d;
        @(negedge clk);
        chk("wr_ready", 32'(wr_ready), 32'h1);
        push_exp(s, d);
        tick();
        wr_valid = 1'b0;
    endtask

    // Clear request collides with a write of 0x1234 to register 2.
    task automatic do_clear();
        int n;
        wr_valid = 1'b1;
        wr_sel   = 3'd2;
        wr_data  = 16'h1234;
        clr_req  = 1'b1;
        @(negedge clk);
        chk("ready_vs_clr", 32'(wr_ready), 32'h0);
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        zero_model();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                n++;
                chk("ready_in_clear", 32'(wr_ready), 32'h0);
                if (n > 1) chk("upd_in_clear", 32'(upd), 32'h0);
                clr_req = (n == 3);
            end else if (n > 0) begin
                break;
            end
            tick();
        end
        clr_req = 1'b0;
        chk("busy_cycles", 32'(n), 32'd8);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && upd !== 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("upd_spurious", 32'(upd), 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("upd_onehot", 32'(upd), 32'(1) << e.sel);
                chk("commit_data", 32'(outs[e.sel]), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        zero_model();

        idle(2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        chk("rst_upd", 32'(upd), 32'h0);
        check_all();
        rst_n = 1'b1;
        tick();

        // single write, one-cycle commit latency
        do_write(3'd5, 16'hBEEF);
        chk("lat_upd_early", 32'(upd), 32'h0);
        chk("lat_out5_early", 32'(out5), 32'h0);
        tick();
        chk("lat_upd", 32'(upd), 32'h20);
        chk("lat_out5", 32'(out5), 32'hBEEF);
        idle(1);
        check_all();

        for (int k = 0; k < 8; k++) do_write(3'(k), 16'h1000 + 16'(k));
        idle(2);
        check_all();

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) tick();
            else do_write(3'($urandom_range(0, 7)), 16'($urandom));
        end
        idle(2);
        check_all();

        // a write still in the accept stage commits before the sweep
        do_write(3'd6, 16'hA5A5);
        do_clear();
        check_all();
        do_write(3'd2, 16'h1234);
        idle(2);
        check_all();

        // reset while the sweep is at index 3
        for (int k = 0; k < 8; k++) do_write(3'(k), 16'($urandom) | 16'h0001);
        idle(2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        idle(3);
        chk("busy_mid", 32'(busy), 32'h1);
        chk("out7_mid_clear", 32'(out7), 32'(mem[7]));
        rst_n = 1'b0;
        tick();
        zero_model();
        chk("rst_clr_busy", 32'(busy), 32'h0);
        chk("rst_clr_ready", 32'(wr_ready), 32'h1);
        chk("rst_clr_upd", 32'(upd), 32'h0);
        check_all();
        rst_n = 1'b1;
        tick();

        // reset with a write held in the accept stage discards it
        wr_valid = 1'b1;
        wr_sel   = 3'd3;
        wr_data  = 16'h5555;
        tick();
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(3);
        check_all();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
